approx_mult_err_monitor: RTL

- Downstream consumer of the 8x8 approximate multiplier used during characterisation runs.
- Accepts a stream of operand pairs A, B together with the approximate product R through a valid/ready handshake.
- Recomputes the exact product internally in a pipelined path and accumulates error statistics over a programmed number of samples: erroneous-result count, sum of absolute error distance, and maximum error with the operands that produced it.
- Results are held until the next run starts.

---
 rtl/approx_mult_err_monitor_if.sv | 29 ++
 rtl/approx_mult_err_monitor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_err_monitor_if.sv
// Sample stream from the approximate multiplier under characterisation:
// operand pair plus the approximate product, with a valid/ready handshake.
interface approx_mult_err_monitor_if #(
  parameter int unsigned W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [2*W-1:0]   r_apx;

  // Producer side (multiplier / stimulus source).
  modport master (
    output in_valid,
    output a,
    output b,
    output r_apx,
    input  in_ready
  );

  // Consumer side (error monitor).
  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  r_apx,
    output in_ready
  );
endinterface

// File: rtl/approx_mult_err_monitor.sv
// Error-statistics monitor for an approximate W x W multiplier.
// Recomputes the exact product in a three-stage pipeline and accumulates, over a
// programmed number of samples, the count of wrong results, the saturating sum of
// absolute error distances and the largest error together with its operands.
module approx_mult_err_monitor #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 24,
  parameter int unsigned SUM_W = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CNT_W-1:0]        sample_count,
  approx_mult_err_monitor_if.slave samples,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        err_count,
  output logic [SUM_W-1:0]        sum_abs_err,
  output logic [2*W-1:0]          max_abs_err,
  output logic [W-1:0]            max_err_a,
  output logic [W-1:0]            max_err_b
);

  localparam int unsigned PW = 2 * W;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e           state;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] accepted;
  logic [CNT_W-1:0] accepted_next;
  logic             ready_q;
  logic             fire;
  logic             start_ok;

  // Stage 1: captured sample.
  logic             v1;
  logic [W-1:0]     a1;
  logic [W-1:0]     b1;
  logic [PW-1:0]    r1;
  // Stage 2: exact product alongside the approximate one.
  logic             v2;
  logic [W-1:0]     a2;
  logic [W-1:0]     b2;
  logic [PW-1:0]    r2;
  logic [PW-1:0]    exact2;
  // Stage 3: absolute error distance.
  logic             v3;
  logic [W-1:0]     a3;
  logic [W-1:0]     b3;
  logic [PW-1:0]    d3;

  logic [PW-1:0]    diff2;
  logic [SUM_W:0]   sum_ext;
  logic [SUM_W-1:0] sum_next;

  // ready is registered, so the handshake never looks combinationally at in_valid.
  assign samples.in_ready = ready_q;
  assign fire             = samples.in_valid & ready_q;
  assign start_ok         = (state == StIdle) & start;
  assign accepted_next    = accepted + CntOne;

  // Run control: sample budget, handshake gating, drain and the done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= StIdle;
      target   <= '0;
      accepted <= '0;
      ready_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            target   <= sample_count;
            accepted <= '0;
            busy     <= 1'b1;
            if (sample_count == '0) begin
              state   <= StDrain;
              ready_q <= 1'b0;
            end else begin
              state   <= StRun;
              ready_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (fire) begin
            accepted <= accepted_next;
            // Final sample: stop accepting on the very edge that takes it.
            if (accepted_next >= target) begin
              state   <= StDrain;
              ready_q <= 1'b0;
            end
          end
        end
        StDrain: begin
          // Stage 3 is consumed on this same edge, so only stages 1 and 2 must be empty.
          if (!v1 && !v2) begin
            state <= StDone;
            busy  <= 1'b0;
          end
        end
        StDone: begin
          done  <= 1'b1;
          state <= StIdle;
        end
        default: begin
          state   <= StIdle;
          ready_q <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Unsigned compare-and-subtract gives |exact - r_apx| in either direction.
  always_comb begin
    diff2 = '0;
    if (exact2 >= r2) begin
      diff2 = exact2 - r2;
    end else begin
      diff2 = r2 - exact2;
    end
  end

  // Three-stage datapath: capture, exact multiply, absolute difference.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      a1     <= '0;
      b1     <= '0;
      r1     <= '0;
      v2     <= 1'b0;
      a2     <= '0;
      b2     <= '0;
      r2     <= '0;
      exact2 <= '0;
      v3     <= 1'b0;
      a3     <= '0;
      b3     <= '0;
      d3     <= '0;
    end else begin
      v1 <= fire;
      if (fire) begin
        a1 <= samples.a;
        b1 <= samples.b;
        r1 <= samples.r_apx;
      end
      v2 <= v1;
      if (v1) begin
        a2     <= a1;
        b2     <= b1;
        r2     <= r1;
        exact2 <= PW'(a1) * PW'(b1);
      end
      v3 <= v2;
      if (v2) begin
        a3 <= a2;
        b3 <= b2;
        d3 <= diff2;
      end
    end
  end

  // One extra carry bit detects accumulator overflow; clamp to all-ones on overflow.
  assign sum_ext  = {1'b0, sum_abs_err} + (SUM_W + 1)'(d3);
  assign sum_next = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];

  // Statistics: cleared by an accepted start, updated by each valid stage-3 result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count   <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
      max_err_a   <= '0;
      max_err_b   <= '0;
    end else if (start_ok) begin
      err_count   <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
      max_err_a   <= '0;
      max_err_b   <= '0;
    end else if (v3) begin
      if (d3 != '0) begin
        err_count <= err_count + CntOne;
      end
      sum_abs_err <= sum_next;
      // Strictly greater: on a tie the earlier sample's operands are kept.
      if (d3 > max_abs_err) begin
        max_abs_err <= d3;
        max_err_a   <= a3;
        max_err_b   <= b3;
      end
    end
  end

endmodule
